// File: rtl/mem_io_responder.sv
// mem_io_responder: answers the CPU's active-low SRAM strobes from an on-chip
// 16-bit word array, plus a memory-mapped I/O pair (Switches read, Hex_out write).
//
// Ports:
//   Clk, Reset_n        clock, asynchronous active-low reset
//   Mem_CE/OE/WE        chip enable, read strobe, write strobe (active low)
//   Mem_UB/Mem_LB       byte-lane enables for [15:8] / [7:0] (active low)
//   ADDR                word address from MAR
//   Data_from_CPU       write data from MDR
//   Data_to_CPU         registered read data
//   Switches            board switches, returned for reads of IO_ADDR
//   Hex_out             hex-display latch, loaded by writes to IO_ADDR
//   Bus_err             one-cycle pulse after an edge with OE and WE both low
module mem_io_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Mem_CE,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic        Mem_UB,
  input  logic        Mem_LB,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  output logic [15:0] Data_to_CPU,
  input  logic [15:0] Switches,
  output logic [15:0] Hex_out,
  output logic        Bus_err
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_HOLD = 2'd1,
    WR_HOLD = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   idx_c;
  logic                io_hit_c;
  logic                wr_commit_c;
  logic                rd_commit_c;
  logic                conflict_c;
  logic                wr_mem_c;
  logic                wr_io_c;

  // Non-I/O addresses alias modulo the array depth.
  assign idx_c    = ADDR[ADDR_W-1:0];
  assign io_hit_c = (ADDR == IO_ADDR);

  // Next-state and commit decode; commits happen only on the IDLE edge.
  always_comb begin
    state_d     = state_q;
    wr_commit_c = 1'b0;
    rd_commit_c = 1'b0;
    conflict_c  = 1'b0;
    if (Mem_CE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!Mem_WE) begin
            // Write wins over a simultaneous read; the read is dropped.
            wr_commit_c = 1'b1;
            conflict_c  = !Mem_OE;
            state_d     = WR_HOLD;
          end else if (!Mem_OE) begin
            rd_commit_c = 1'b1;
            state_d     = RD_HOLD;
          end
        end
        RD_HOLD: if (Mem_OE) state_d = IDLE;
        WR_HOLD: if (Mem_WE) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Gating with Reset_n keeps a write from landing while reset is held.
  assign wr_mem_c = wr_commit_c && !io_hit_c && Reset_n;
  assign wr_io_c  = wr_commit_c && io_hit_c;

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Word array: no reset, byte-lane writes.
  always_ff @(posedge Clk) begin
    if (wr_mem_c) begin
      if (!Mem_UB) mem[idx_c][15:8] <= Data_from_CPU[15:8];
      if (!Mem_LB) mem[idx_c][7:0]  <= Data_from_CPU[7:0];
    end
  end

  // Registered outputs: read data, hex latch, conflict pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Data_to_CPU <= 16'h0000;
      Hex_out     <= 16'h0000;
      Bus_err     <= 1'b0;
    end else begin
      Bus_err <= conflict_c;
      if (rd_commit_c) begin
        Data_to_CPU <= io_hit_c ? Switches : mem[idx_c];
      end
      if (wr_io_c) begin
        if (!Mem_UB) Hex_out[15:8] <= Data_from_CPU[15:8];
        if (!Mem_LB) Hex_out[7:0]  <= Data_from_CPU[7:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: the driver queues expected read data,
// a bus monitor detects read commits and compares Data_to_CPU on the next two
// falling edges (first valid cycle and the hold cycle).
module tb_mem_io_responder;

  localparam logic [15:0] IO = 16'hFFFF;

  logic        Clk;
  logic        Reset_n;
  logic        Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic [15:0] Data_to_CPU;
  logic [15:0] Switches;
  logic [15:0] Hex_out;
  logic        Bus_err;

  typedef struct {
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  mem_io_responder #(.ADDR_W(10), .IO_ADDR(IO)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .Mem_CE        (Mem_CE),
    .Mem_OE        (Mem_OE),
    .Mem_WE        (Mem_WE),
    .Mem_UB        (Mem_UB),
    .Mem_LB        (Mem_LB),
    .ADDR          (ADDR),
    .Data_from_CPU (Data_from_CPU),
    .Data_to_CPU   (Data_to_CPU),
    .Switches      (Switches),
    .Hex_out       (Hex_out),
    .Bus_err       (Bus_err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_idle();
    Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Mem_UB = 1'b1; Mem_LB = 1'b1;
  endtask

  // Two-cycle write strobe; d2 is presented during the second WE-low cycle.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d1,
                          input logic [15:0] d2, input logic ub, input logic lb);
    @(negedge Clk);
    Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_UB = ub; Mem_LB = lb;
    ADDR = a; Data_from_CPU = d1;
    @(negedge Clk);
    Data_from_CPU = d2;
    @(negedge Clk);
    bus_idle();
  endtask

  // Two-cycle read strobe; ADDR moves to a2 in the hold cycle.
  task automatic do_read(input logic [15:0] a, input logic [15:0] a2,
                         input logic [15:0] exp, input string nm);
    exp_q.push_back('{val: exp, name: nm});
    @(negedge Clk);
    Mem_CE = 1'b0; Mem_OE = 1'b0; ADDR = a;
    @(negedge Clk);
    ADDR = a2;
    @(negedge Clk);
    bus_idle();
  endtask

  // Monitor: a read commit is the first edge with CE, OE low and WE high.
  initial begin
    logic rd_now;
    logic prev_rd;
    exp_t e;
    prev_rd = 1'b0;
    forever begin
      @(posedge Clk);
      rd_now = Reset_n && !Mem_CE && !Mem_OE && Mem_WE;
      if (rd_now && !prev_rd) begin
        @(negedge Clk);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_read: got %h expected no read", Data_to_CPU);
        end else begin
          e = exp_q.pop_front();
          check(e.name, Data_to_CPU, e.val);
          @(negedge Clk);
          check({e.name, "_hold"}, Data_to_CPU, e.val);
        end
      end
      prev_rd = rd_now;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b0;
    Switches = 16'hDEAD;
    ADDR = 16'h0000;
    Data_from_CPU = 16'h0000;
    bus_idle();
    repeat (3) @(negedge Clk);
    check("rst_data", Data_to_CPU, 16'h0000);
    check("rst_hex", Hex_out, 16'h0000);
    check("rst_buserr", 16'(Bus_err), 16'h0000);
    Reset_n = 1'b1;

    // Word write and readback.
    do_write(16'h0012, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
    do_read(16'h0012, IO, 16'hBEEF, "word_rb");

    // Upper lane only.
    do_write(16'h0005, 16'h1234, 16'h1234, 1'b0, 1'b0);
    do_write(16'h0005, 16'hABCD, 16'hABCD, 1'b0, 1'b1);
    do_read(16'h0005, IO, 16'hAB34, "ub_lane");

    // Lower lane only, then no lanes.
    do_write(16'h0006, 16'h1234, 16'h1234, 1'b0, 1'b0);
    do_write(16'h0006, 16'hABCD, 16'hABCD, 1'b1, 1'b0);
    do_write(16'h0006, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    do_read(16'h0006, IO, 16'h12CD, "lb_lane");

    // Single commit per strobe.
    do_write(16'h0007, 16'h1111, 16'h2222, 1'b0, 1'b0);
    do_read(16'h0007, IO, 16'h1111, "single_commit");

    // Aliasing modulo 1024 words.
    do_write(16'h0401, 16'h00AA, 16'h00AA, 1'b0, 1'b0);
    do_read(16'h0001, IO, 16'h00AA, "alias");

    // I/O read of Switches.
    Switches = 16'h5A5A;
    do_read(IO, 16'h0012, 16'h5A5A, "io_read");
    Switches = 16'hDEAD;

    // I/O write loads Hex_out and leaves array word 0x3FF alone.
    do_write(16'h03FF, 16'h3333, 16'h3333, 1'b0, 1'b0);
    do_write(IO, 16'h0C0D, 16'hFFFF, 1'b0, 1'b0);
    check("io_hex", Hex_out, 16'h0C0D);
    do_read(16'h03FF, IO, 16'h3333, "io_no_array");

    // CE high blocks writes to array and I/O.
    @(negedge Clk);
    Mem_CE = 1'b1; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
    ADDR = 16'h0012; Data_from_CPU = 16'h0000;
    @(negedge Clk);
    ADDR = IO;
    @(negedge Clk);
    bus_idle();
    check("ce_gate_hex", Hex_out, 16'h0C0D);
    do_read(16'h0012, IO, 16'hBEEF, "ce_gate");

    // OE and WE both low: write commits, Bus_err pulses once.
    @(negedge Clk);
    Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_OE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
    ADDR = 16'h0040; Data_from_CPU = 16'h4444;
    @(negedge Clk);
    check("conflict_pulse", 16'(Bus_err), 16'h0001);
    @(negedge Clk);
    check("conflict_pulse_end", 16'(Bus_err), 16'h0000);
    bus_idle();
    do_read(16'h0040, IO, 16'h4444, "conflict_wr");

    // Back-to-back writes: WE high for one edge yields a second commit.
    @(negedge Clk);
    Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
    ADDR = 16'h0050; Data_from_CPU = 16'h1010;
    @(negedge Clk);
    Mem_WE = 1'b1; Data_from_CPU = 16'h2020;
    @(negedge Clk);
    Mem_WE = 1'b0;
    @(negedge Clk);
    bus_idle();
    do_read(16'h0050, IO, 16'h2020, "b2b_write");

    // Reset mid WR_HOLD, then writes attempted while reset is held.
    do_write(16'h0030, 16'h1357, 16'h1357, 1'b0, 1'b0);
    @(negedge Clk);
    Mem_CE = 1'b0; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
    ADDR = 16'h0020; Data_from_CPU = 16'h7777;
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("midrst_data", Data_to_CPU, 16'h0000);
    check("midrst_hex", Hex_out, 16'h0000);
    check("midrst_buserr", 16'(Bus_err), 16'h0000);
    ADDR = 16'h0030; Data_from_CPU = 16'h9999;
    repeat (2) @(negedge Clk);
    bus_idle();
    @(negedge Clk);
    Reset_n = 1'b1;
    do_read(16'h0030, IO, 16'h1357, "rst_no_write");
    do_read(16'h0020, IO, 16'h7777, "rst_prior_commit");

    repeat (2) @(negedge Clk);
    check("sb_drain", 16'(exp_q.size()), 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
